// File: rtl/phys_reg_free_list_if.sv
// Rename/commit-side signal bundle for the physical register free list.
// The master (rename + commit) drives requests and releases; the slave (free list)
// answers with grants, offered indices, the free count and the sticky overflow flag.
interface phys_reg_free_list_if #(
    parameter int IDX_W = 6
);
    logic             en;
    logic [0:3]       allocReq;
    logic             allocAck;
    logic [IDX_W-1:0] allocSel0;
    logic [IDX_W-1:0] allocSel1;
    logic [IDX_W-1:0] allocSel2;
    logic [IDX_W-1:0] allocSel3;
    logic [0:3]       freeReq;
    logic [IDX_W-1:0] freeSel0;
    logic [IDX_W-1:0] freeSel1;
    logic [IDX_W-1:0] freeSel2;
    logic [IDX_W-1:0] freeSel3;
    logic [IDX_W:0]   freeCount;
    logic             overflowErr;

    modport master (
        output en, allocReq, freeReq, freeSel0, freeSel1, freeSel2, freeSel3,
        input  allocAck, allocSel0, allocSel1, allocSel2, allocSel3, freeCount, overflowErr
    );

    modport slave (
        input  en, allocReq, freeReq, freeSel0, freeSel1, freeSel2, freeSel3,
        output allocAck, allocSel0, allocSel1, allocSel2, allocSel3, freeCount, overflowErr
    );
endinterface

// File: rtl/phys_reg_free_list.sv
// Physical register free list: circular FIFO of free indices.
// Rename takes up to 4 indices per cycle as an all-or-nothing group, compacted onto
// consecutive FIFO entries in lane order; commit returns up to 4 indices per cycle.
// Grants look only at the registered count, so releases become visible next cycle.
module phys_reg_free_list #(
    parameter int NUM_PHYS  = 64,
    parameter int IDX_W     = 6,
    parameter int INIT_FREE = 32
) (
    input  logic clk,
    input  logic reset,
    phys_reg_free_list_if.slave bus
);
    localparam int CNT_W = IDX_W + 1;

    typedef logic [IDX_W-1:0] idx_t;

    idx_t             fifo_q [NUM_PHYS];
    idx_t             fifo_d [NUM_PHYS];
    idx_t             rd_ptr_q, rd_ptr_d;
    idx_t             wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;

    logic [0:3]       alloc_req;
    logic [0:3]       free_req;
    idx_t             free_sel  [4];
    idx_t             alloc_sel [4];
    logic [2:0]       alloc_off [4];
    logic [2:0]       free_off  [4];
    logic [2:0]       alloc_n;
    logic [2:0]       free_n;
    logic [2:0]       pop_n;
    logic [2:0]       push_n;
    logic [CNT_W:0]   room;
    logic [0:3]       accept;
    logic             alloc_ack;

    assign alloc_req   = bus.allocReq;
    assign free_req    = bus.freeReq;
    assign free_sel[0] = bus.freeSel0;
    assign free_sel[1] = bus.freeSel1;
    assign free_sel[2] = bus.freeSel2;
    assign free_sel[3] = bus.freeSel3;

    assign bus.allocAck    = alloc_ack;
    assign bus.allocSel0   = alloc_sel[0];
    assign bus.allocSel1   = alloc_sel[1];
    assign bus.allocSel2   = alloc_sel[2];
    assign bus.allocSel3   = alloc_sel[3];
    assign bus.freeCount   = count_q;
    assign bus.overflowErr = overflow_q;

    // Grant decision and lane-compacted read offers; grant is held off while in reset.
    always_comb begin
        alloc_n = '0;
        for (int k = 0; k < 4; k++) begin
            alloc_off[k] = alloc_n;
            alloc_n      = alloc_n + {2'b00, alloc_req[k]};
        end
        alloc_ack = reset && bus.en && (alloc_n != '0) && (count_q >= CNT_W'(alloc_n));
        for (int k = 0; k < 4; k++) begin
            alloc_sel[k] = fifo_q[rd_ptr_q + idx_t'(alloc_off[k])];
        end
    end

    // Release acceptance (pops this cycle free up room first), pushes and next-state update.
    always_comb begin
        pop_n  = alloc_ack ? alloc_n : 3'd0;
        room   = (CNT_W+1)'(NUM_PHYS) - {1'b0, count_q} + (CNT_W+1)'(pop_n);
        free_n = '0;
        push_n = '0;
        for (int k = 0; k < 4; k++) begin
            free_off[k] = free_n;
            free_n      = free_n + {2'b00, free_req[k]};
            accept[k]   = free_req[k] && ((CNT_W+1)'(free_off[k]) < room);
            push_n      = push_n + {2'b00, accept[k]};
        end
        fifo_d = fifo_q;
        for (int k = 0; k < 4; k++) begin
            if (accept[k]) begin
                fifo_d[wr_ptr_q + idx_t'(free_off[k])] = free_sel[k];
            end
        end
        rd_ptr_d   = rd_ptr_q + idx_t'(pop_n);
        wr_ptr_d   = wr_ptr_q + idx_t'(push_n);
        count_d    = count_q - CNT_W'(pop_n) + CNT_W'(push_n);
        overflow_d = overflow_q || (push_n != free_n);
    end

    // State registers; reset reloads the initial free indices INIT_FREE..NUM_PHYS-1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PHYS; i++) begin
                fifo_q[i] <= (i < NUM_PHYS - INIT_FREE) ? idx_t'(INIT_FREE + i) : '0;
            end
            rd_ptr_q   <= '0;
            wr_ptr_q   <= idx_t'(NUM_PHYS - INIT_FREE);
            count_q    <= CNT_W'(INIT_FREE);
            overflow_q <= 1'b0;
        end else begin
            fifo_q     <= fifo_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end
endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed bench for phys_reg_free_list: reset state, compaction, exhaustion,
// enable gating, full-capacity overlap, pointer wrap and asynchronous reset.
module tb_phys_reg_free_list;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    logic [5:0] exp_q[$];

    phys_reg_free_list_if #(.IDX_W(6)) bus();

    phys_reg_free_list #(.NUM_PHYS(64), .IDX_W(6), .INIT_FREE(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.en       = 1'b0;
        bus.allocReq = 4'b0000;
        bus.freeReq  = 4'b0000;
        bus.freeSel0 = 6'd0;
        bus.freeSel1 = 6'd0;
        bus.freeSel2 = 6'd0;
        bus.freeSel3 = 6'd0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (bus.freeCount !== 7'd32) begin n_fail++; $display("FAIL reset_count got %0d want 32", bus.freeCount); end
        n_checks++; if (bus.overflowErr !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %0b want 0", bus.overflowErr); end
        bus.en = 1'b1; bus.allocReq = 4'b1111;
        #1;
        n_checks++; if (bus.allocAck !== 1'b1) begin n_fail++; $display("FAIL reset_ack got %0b want 1", bus.allocAck); end
        n_checks++; if (bus.allocSel0 !== 6'd32) begin n_fail++; $display("FAIL reset_sel0 got %0d want 32", bus.allocSel0); end
        n_checks++; if (bus.allocSel1 !== 6'd33) begin n_fail++; $display("FAIL reset_sel1 got %0d want 33", bus.allocSel1); end
        n_checks++; if (bus.allocSel2 !== 6'd34) begin n_fail++; $display("FAIL reset_sel2 got %0d want 34", bus.allocSel2); end
        n_checks++; if (bus.allocSel3 !== 6'd35) begin n_fail++; $display("FAIL reset_sel3 got %0d want 35", bus.allocSel3); end
        tick();
        n_checks++; if (bus.freeCount !== 7'd28) begin n_fail++; $display("FAIL alloc4_count got %0d want 28", bus.freeCount); end
        n_checks++; if (bus.allocSel0 !== 6'd36) begin n_fail++; $display("FAIL alloc4_next_sel0 got %0d want 36", bus.allocSel0); end
        bus.allocReq = 4'b0000;
    endtask

    task automatic test_sparse();
        do_reset();
        bus.en = 1'b1; bus.allocReq = 4'b0101;
        #1;
        n_checks++; if (bus.allocAck !== 1'b1) begin n_fail++; $display("FAIL sparse_ack got %0b want 1", bus.allocAck); end
        n_checks++; if (bus.allocSel1 !== 6'd32) begin n_fail++; $display("FAIL sparse_sel1 got %0d want 32", bus.allocSel1); end
        n_checks++; if (bus.allocSel3 !== 6'd33) begin n_fail++; $display("FAIL sparse_sel3 got %0d want 33", bus.allocSel3); end
        tick();
        bus.allocReq = 4'b1000;
        #1;
        n_checks++; if (bus.allocSel0 !== 6'd34) begin n_fail++; $display("FAIL sparse_next_sel0 got %0d want 34", bus.allocSel0); end
        n_checks++; if (bus.freeCount !== 7'd30) begin n_fail++; $display("FAIL sparse_count got %0d want 30", bus.freeCount); end
        bus.allocReq = 4'b0000;
    endtask

    task automatic test_exhaustion();
        do_reset();
        bus.en = 1'b1; bus.allocReq = 4'b1111;
        repeat (8) tick();
        bus.allocReq = 4'b1000;
        bus.freeReq  = 4'b1000;
        bus.freeSel0 = 6'd5;
        #1;
        n_checks++; if (bus.freeCount !== 7'd0) begin n_fail++; $display("FAIL exhaust_count got %0d want 0", bus.freeCount); end
        n_checks++; if (bus.allocAck !== 1'b0) begin n_fail++; $display("FAIL exhaust_ack got %0b want 0", bus.allocAck); end
        tick();
        bus.freeReq = 4'b0000;
        #1;
        n_checks++; if (bus.freeCount !== 7'd1) begin n_fail++; $display("FAIL refill_count got %0d want 1", bus.freeCount); end
        n_checks++; if (bus.allocAck !== 1'b1) begin n_fail++; $display("FAIL refill_ack got %0b want 1", bus.allocAck); end
        n_checks++; if (bus.allocSel0 !== 6'd5) begin n_fail++; $display("FAIL refill_sel0 got %0d want 5", bus.allocSel0); end
        tick();
        bus.allocReq = 4'b0000;
        #1;
        n_checks++; if (bus.freeCount !== 7'd0) begin n_fail++; $display("FAIL refill_drain_count got %0d want 0", bus.freeCount); end
    endtask

    task automatic test_en_gate();
        do_reset();
        bus.en = 1'b1; bus.allocReq = 4'b1111;
        tick();
        bus.en = 1'b0;
        bus.freeReq  = 4'b0011;
        bus.freeSel2 = 6'd40;
        bus.freeSel3 = 6'd41;
        #1;
        n_checks++; if (bus.freeCount !== 7'd28) begin n_fail++; $display("FAIL en_pre_count got %0d want 28", bus.freeCount); end
        n_checks++; if (bus.allocAck !== 1'b0) begin n_fail++; $display("FAIL en_off_ack got %0b want 0", bus.allocAck); end
        tick();
        bus.freeReq  = 4'b0000;
        bus.allocReq = 4'b1000;
        bus.en       = 1'b1;
        #1;
        n_checks++; if (bus.freeCount !== 7'd30) begin n_fail++; $display("FAIL en_off_count got %0d want 30", bus.freeCount); end
        n_checks++; if (bus.allocSel0 !== 6'd36) begin n_fail++; $display("FAIL en_off_rdptr got %0d want 36", bus.allocSel0); end
        bus.allocReq = 4'b0000;
        bus.en       = 1'b0;
    endtask

    task automatic test_full_overlap();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            bus.freeReq  = 4'b1111;
            bus.freeSel0 = 6'(c * 4);
            bus.freeSel1 = 6'(c * 4 + 1);
            bus.freeSel2 = 6'(c * 4 + 2);
            bus.freeSel3 = 6'(c * 4 + 3);
            tick();
        end
        bus.freeReq = 4'b0000;
        #1;
        n_checks++; if (bus.freeCount !== 7'd64) begin n_fail++; $display("FAIL full_count got %0d want 64", bus.freeCount); end
        bus.en = 1'b1; bus.allocReq = 4'b1111;
        bus.freeReq = 4'b1111;
        bus.freeSel0 = 6'd1; bus.freeSel1 = 6'd2; bus.freeSel2 = 6'd3; bus.freeSel3 = 6'd4;
        #1;
        n_checks++; if (bus.allocAck !== 1'b1) begin n_fail++; $display("FAIL full_ack got %0b want 1", bus.allocAck); end
        n_checks++; if (bus.allocSel3 !== 6'd35) begin n_fail++; $display("FAIL full_sel3 got %0d want 35", bus.allocSel3); end
        tick();
        bus.allocReq = 4'b0000;
        bus.freeReq  = 4'b0001;
        bus.freeSel3 = 6'd9;
        #1;
        n_checks++; if (bus.freeCount !== 7'd64) begin n_fail++; $display("FAIL overlap_count got %0d want 64", bus.freeCount); end
        n_checks++; if (bus.overflowErr !== 1'b0) begin n_fail++; $display("FAIL overlap_ovf got %0b want 0", bus.overflowErr); end
        tick();
        bus.freeReq = 4'b0000;
        #1;
        n_checks++; if (bus.freeCount !== 7'd64) begin n_fail++; $display("FAIL drop_count got %0d want 64", bus.freeCount); end
        n_checks++; if (bus.overflowErr !== 1'b1) begin n_fail++; $display("FAIL drop_ovf got %0b want 1", bus.overflowErr); end
        repeat (3) tick();
        n_checks++; if (bus.overflowErr !== 1'b1) begin n_fail++; $display("FAIL sticky_ovf got %0b want 1", bus.overflowErr); end
        bus.en = 1'b0;
    endtask

    task automatic test_wrap();
        logic [5:0] sels [4];
        logic [5:0] rel  [4];
        logic [5:0] exp_v;
        do_reset();
        exp_q.delete();
        for (int i = 32; i < 64; i++) exp_q.push_back(6'(i));
        bus.en = 1'b1;
        for (int c = 0; c < 20; c++) begin
            for (int k = 0; k < 4; k++) rel[k] = 6'((c * 4 + k) * 5 + 1);
            bus.allocReq = 4'b1111;
            bus.freeReq  = 4'b1111;
            bus.freeSel0 = rel[0]; bus.freeSel1 = rel[1];
            bus.freeSel2 = rel[2]; bus.freeSel3 = rel[3];
            #1;
            sels[0] = bus.allocSel0; sels[1] = bus.allocSel1;
            sels[2] = bus.allocSel2; sels[3] = bus.allocSel3;
            n_checks++; if (bus.allocAck !== 1'b1) begin n_fail++; $display("FAIL wrap_ack cycle %0d got %0b want 1", c, bus.allocAck); end
            n_checks++; if (bus.freeCount !== 7'd32) begin n_fail++; $display("FAIL wrap_count cycle %0d got %0d want 32", c, bus.freeCount); end
            for (int k = 0; k < 4; k++) begin
                exp_v = exp_q.pop_front();
                n_checks++; if (sels[k] !== exp_v) begin n_fail++; $display("FAIL wrap_sel cycle %0d lane %0d got %0d want %0d", c, k, sels[k], exp_v); end
            end
            for (int k = 0; k < 4; k++) exp_q.push_back(rel[k]);
            tick();
        end
        bus.allocReq = 4'b0000;
        bus.freeReq  = 4'b0000;
        #1;
        n_checks++; if (bus.freeCount !== 7'd32) begin n_fail++; $display("FAIL wrap_end_count got %0d want 32", bus.freeCount); end
        bus.allocReq = 4'b1000;
        #1;
        exp_v = exp_q[0];
        n_checks++; if (bus.allocSel0 !== exp_v) begin n_fail++; $display("FAIL wrap_end_sel0 got %0d want %0d", bus.allocSel0, exp_v); end
        bus.allocReq = 4'b0000;
    endtask

    task automatic test_async_reset();
        bus.en = 1'b1; bus.allocReq = 4'b1111;
        tick();
        n_checks++; if (bus.freeCount !== 7'd28) begin n_fail++; $display("FAIL arst_pre_count got %0d want 28", bus.freeCount); end
        #2;
        reset = 1'b0;
        #1;
        n_checks++; if (bus.freeCount !== 7'd32) begin n_fail++; $display("FAIL arst_count got %0d want 32", bus.freeCount); end
        n_checks++; if (bus.allocAck !== 1'b0) begin n_fail++; $display("FAIL arst_ack got %0b want 0", bus.allocAck); end
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (bus.allocAck !== 1'b1) begin n_fail++; $display("FAIL arst_release_ack got %0b want 1", bus.allocAck); end
        n_checks++; if (bus.allocSel0 !== 6'd32) begin n_fail++; $display("FAIL arst_release_sel0 got %0d want 32", bus.allocSel0); end
        clear_inputs();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        clear_inputs();
        test_reset();
        test_sparse();
        test_exhaustion();
        test_en_gate();
        test_full_overlap();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
